// File: rtl/serial_adder_ctrl_if.sv
// Start/done handshake bundle between a requester and the bit-serial adder sequencer.
// The requester drives the operands and start; the sequencer returns status and the held result.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             ci_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             co;

  modport master (
    output start, a_in, b_in, ci_in,
    input  busy, done, sum, co
  );

  modport slave (
    input  start, a_in, b_in, ci_in,
    output busy, done, sum, co
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial sequencer that builds a WIDTH-bit adder around an external 1-bit full adder cell.
// It feeds operand bits LSB first, registers the returned carry and assembles the sum.
module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_ctrl_if.slave   bus,
  output logic                 fa_a,
  output logic                 fa_b,
  output logic                 fa_ci,
  input  logic                 fa_s,
  input  logic                 fa_co
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] sum_sh_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             co_r;
  logic [CNT_W-1:0] count_r;
  logic             busy_r;
  logic             done_r;
  logic             last_bit_s;

  assign last_bit_s = (count_r == CNT_W'(WIDTH - 1));

  // Next-state decode for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_bit_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath, state and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      sum_sh_r <= {WIDTH{1'b0}};
      sum_r    <= {WIDTH{1'b0}};
      carry_r  <= 1'b0;
      co_r     <= 1'b0;
      count_r  <= {CNT_W{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            a_sh_r  <= bus.a_in;
            b_sh_r  <= bus.b_in;
            carry_r <= bus.ci_in;
            count_r <= {CNT_W{1'b0}};
          end
        end
        ST_RUN: begin
          sum_sh_r <= {fa_s, sum_sh_r[WIDTH-1:1]};
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          if (last_bit_s) begin
            sum_r   <= {fa_s, sum_sh_r[WIDTH-1:1]};
            co_r    <= fa_co;
            // The operand shifters are empty by now; clearing the carry too keeps the
            // adder drive at zero outside RUN while still coming straight from flops.
            carry_r <= 1'b0;
            count_r <= {CNT_W{1'b0}};
          end else begin
            carry_r <= fa_co;
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          carry_r <= 1'b0;
        end
        default: begin
          carry_r <= 1'b0;
        end
      endcase
    end
  end

  assign fa_a     = a_sh_r[0];
  assign fa_b     = b_sh_r[0];
  assign fa_ci    = carry_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.co   = co_r;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl with a behavioural full adder and an arithmetic reference.
module tb_serial_adder_ctrl;
  logic clk;
  logic rst_n;
  logic fa_a, fa_b, fa_ci, fa_s, fa_co;
  int   vectors;
  int   miscompares;
  logic [7:0] last_sum;
  logic       last_co;

  serial_adder_ctrl_if #(.WIDTH(8)) bus ();

  serial_adder_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .fa_a  (fa_a),
    .fa_b  (fa_b),
    .fa_ci (fa_ci),
    .fa_s  (fa_s),
    .fa_co (fa_co)
  );

  assign fa_s  = fa_a ^ fa_b ^ fa_ci;
  assign fa_co = (fa_a & fa_b) | (fa_a & fa_ci) | (fa_b & fa_ci);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Carry entering bit i of a + b + ci, from the sum of the low i bits.
  function automatic logic carry_into(input logic [7:0] a, input logic [7:0] b, input logic ci, input int i);
    logic [8:0] m;
    logic [8:0] t;
    m = (9'd1 << i) - 9'd1;
    t = (9'(a) & m) + (9'(b) & m) + 9'(ci);
    return t[i];
  endfunction

  task automatic check_fa_zero(input string tag);
    check({tag, "_fa_a"}, 32'(fa_a), 32'd0);
    check({tag, "_fa_b"}, 32'(fa_b), 32'd0);
    check({tag, "_fa_ci"}, 32'(fa_ci), 32'd0);
  endtask

  // One addition from IDLE; glitch_cyc > 0 pulses start and changes a_in in that RUN cycle.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic ci, input int glitch_cyc);
    logic [8:0] exp;
    int cyc;
    exp = 9'(a) + 9'(b) + 9'(ci);
    check_fa_zero("idle");
    bus.start = 1'b1; bus.a_in = a; bus.b_in = b; bus.ci_in = ci;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 20) begin
      check("run_fa_a", 32'(fa_a), 32'(a[cyc]));
      check("run_fa_b", 32'(fa_b), 32'(b[cyc]));
      check("run_fa_ci", 32'(fa_ci), 32'(carry_into(a, b, ci, cyc)));
      check("run_sum_held", 32'(bus.sum), 32'(last_sum));
      check("run_co_held", 32'(bus.co), 32'(last_co));
      check("run_done_low", 32'(bus.done), 32'd0);
      cyc++;
      if (cyc == glitch_cyc) begin
        bus.start = 1'b1; bus.a_in = 8'h11;
      end
      @(negedge clk);
      bus.start = 1'b0;
    end
    check("busy_len", 32'(cyc), 32'd8);
    check("done_high", 32'(bus.done), 32'd1);
    check("sum", 32'(bus.sum), 32'(exp[7:0]));
    check("co", 32'(bus.co), 32'(exp[8]));
    check_fa_zero("done");
    last_sum = exp[7:0];
    last_co  = exp[8];
    @(negedge clk);
    check("done_pulse_end", 32'(bus.done), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int t;
    int pulses;
    int prev_t;
    logic [7:0] ra, rb;
    logic rci;
    logic [8:0] bexp;
    vectors = 0; miscompares = 0;
    last_sum = 8'h00; last_co = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a_in = 8'h00; bus.b_in = 8'h00; bus.ci_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_co", 32'(bus.co), 32'd0);
    check_fa_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h00, 8'h00, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'hA5, 8'h5A, 1'b1, 0);
    run_op(8'h3C, 8'h42, 1'b0, 0);
    run_op(8'h0F, 8'h01, 1'b0, 4);

    // Abort mid-run: outputs clear immediately and no completion follows.
    bus.start = 1'b1; bus.a_in = 8'h12; bus.b_in = 8'h34; bus.ci_in = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("pre_abort_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_done", 32'(bus.done), 32'd0);
    check("abort_sum", 32'(bus.sum), 32'd0);
    check("abort_co", 32'(bus.co), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_sum = 8'h00; last_co = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_done", 32'(bus.done | bus.busy), 32'd0);
    end
    run_op(8'h80, 8'h80, 1'b0, 0);

    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rci = 1'($urandom);
      run_op(ra, rb, rci, 0);
    end

    // start held high: back-to-back runs with completions every 10 cycles.
    ra = 8'($urandom); rb = 8'($urandom); rci = 1'($urandom);
    bexp = 9'(ra) + 9'(rb) + 9'(rci);
    bus.start = 1'b1; bus.a_in = ra; bus.b_in = rb; bus.ci_in = rci;
    pulses = 0; prev_t = 0;
    for (t = 1; t <= 45; t++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        check("b2b_sum", 32'(bus.sum), 32'(bexp[7:0]));
        check("b2b_co", 32'(bus.co), 32'(bexp[8]));
        if (pulses > 0) begin
          check("b2b_spacing", 32'(t - prev_t), 32'd10);
        end
        prev_t = t;
        pulses++;
      end
    end
    bus.start = 1'b0;
    check("b2b_pulses", 32'(pulses), 32'd4);
    t = 0;
    while ((bus.busy === 1'b1 || bus.done === 1'b1) && t < 15) begin
      @(negedge clk);
      t++;
    end
    check("b2b_drain", 32'(bus.busy | bus.done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
